// File: rtl/crc_msg_sequencer.sv
// crc_msg_sequencer
//   Control stage in front of the bit-serial crc32 engine. A message
//   descriptor (length, seed, polynomial/orientation vector) is latched in
//   IDLE. The seed is loaded into the engine, and the message words are then
//   fed one per engine pass from a small input FIFO. The final CRC is returned
//   on a valid/ack result port.
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   msg_start/len/seed/poly   descriptor strobe and fields (sampled in IDLE)
//   msg_busy               high while a message is in progress (incl. DONE)
//   msg_err                sticky: msg_start seen while not IDLE
//   word_valid/data/ready  input word stream into the FIFO
//   res_valid/data/ack     final CRC, held until acknowledged
//   crc_start/reset        one-cycle engine strobes (word pass / seed load)
//   crc_data_in            engine data or seed, zero when no strobe is active
//   crc_orient             latched poly vector, held stable for the engine
//   crc_ready/data_out     engine idle flag and CRC register
module crc_msg_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             msg_start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      msg_seed,
  input  logic [31:0]      msg_poly,
  output logic             msg_busy,
  output logic             msg_err,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  output logic             word_ready,
  output logic             res_valid,
  output logic [31:0]      res_data,
  input  logic             res_ack,
  output logic             crc_start,
  output logic             crc_reset,
  output logic [31:0]      crc_data_in,
  output logic [31:0]      crc_orient,
  input  logic             crc_ready,
  input  logic [31:0]      crc_data_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        seed_q, seed_d;
  logic [31:0]        poly_q, poly_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [31:0]        res_q, res_d;
  logic               err_q, err_d;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_q [DEPTH];

  logic               fifo_empty;
  logic               fifo_full;
  logic [31:0]        fifo_head;
  logic               push;
  logic               pop;

  logic               start_c;
  logic               reset_c;
  logic [31:0]        data_c;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_head  = mem_q[rd_ptr_q];

  // Words are only taken for the message in progress and never past its
  // length; DONE is excluded so nothing leaks into the next message.
  assign word_ready = (state_q != S_IDLE) && (state_q != S_DONE) &&
                      !fifo_full && (acc_q < len_q);
  assign push       = word_valid && word_ready;

  assign msg_busy    = (state_q != S_IDLE);
  assign msg_err     = err_q;
  assign res_valid   = (state_q == S_DONE);
  assign res_data    = res_q;
  assign crc_start   = start_c;
  assign crc_reset   = reset_c;
  assign crc_data_in = data_c;
  assign crc_orient  = poly_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    seed_d  = seed_q;
    poly_d  = poly_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    res_d   = res_q;
    err_d   = err_q;
    start_c = 1'b0;
    reset_c = 1'b0;
    data_c  = 32'h0;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (msg_start) begin
          len_d  = msg_len;
          seed_d = msg_seed;
          poly_d = msg_poly;
          rem_d  = msg_len;
          acc_d  = '0;
          err_d  = 1'b0;
          if (msg_len == '0) begin
            // Empty message: the CRC of nothing is the seed itself.
            res_d   = msg_seed;
            state_d = S_DONE;
          end else begin
            state_d = S_SEED;
          end
        end
      end

      S_SEED: begin
        if (crc_ready) begin
          reset_c = 1'b1;
          data_c  = seed_q;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!fifo_empty && crc_ready) begin
          start_c = 1'b1;
          data_c  = fifo_head;
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (crc_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            res_d   = crc_data_out;
            state_d = S_DONE;
          end else if (!fifo_empty) begin
            // Restart on the same cycle the engine frees up so consecutive
            // passes leave no idle gap.
            start_c = 1'b1;
            data_c  = fifo_head;
            pop     = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_DONE: begin
        if (res_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (msg_start && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    if (push) begin
      acc_d = acc_q + LEN_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      seed_q   <= '0;
      poly_q   <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      seed_q   <= seed_d;
      poly_q   <= poly_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_data;
    end
  end

endmodule

// File: tb/tb_crc_msg_sequencer.sv
// Testbench for crc_msg_sequencer: bit-serial engine model, word source,
// result scoreboard with an independent monitor, directed message vectors.
module tb_crc_msg_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             msg_start;
  logic [LEN_W-1:0] msg_len;
  logic [31:0]      msg_seed;
  logic [31:0]      msg_poly;
  logic             msg_busy;
  logic             msg_err;
  logic             word_valid;
  logic [31:0]      word_data;
  logic             word_ready;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             res_ack;
  logic             crc_start;
  logic             crc_reset;
  logic [31:0]      crc_data_in;
  logic [31:0]      crc_orient;
  logic             crc_ready;
  logic [31:0]      crc_data_out;

  crc_msg_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .msg_start(msg_start), .msg_len(msg_len), .msg_seed(msg_seed), .msg_poly(msg_poly),
    .msg_busy(msg_busy), .msg_err(msg_err),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ack(res_ack),
    .crc_start(crc_start), .crc_reset(crc_reset), .crc_data_in(crc_data_in),
    .crc_orient(crc_orient), .crc_ready(crc_ready), .crc_data_out(crc_data_out)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_words[$];
  logic [31:0] wq[$];
  logic [31:0] acc_log[$];
  logic [31:0] sd_q[$];
  int          st_q[$];
  int          cyc = 0, t_start = 0, t_valid = 0;
  int          n_reset = 0, occ = 0, cur_len = 0;
  int          dz_bad = 0, orient_bad = 0, full_bad = 0, over_bad = 0;
  logic        rv_prev = 1'b0;
  logic [31:0] rst_data = 32'h0;
  logic [31:0] exp_poly = 32'h0;
  logic [31:0] tmp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] c, input logic b, input logic [31:0] p);
    step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? p : 32'h0);
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] seed, input logic [31:0] poly, input int n);
    logic [31:0] c;
    logic [31:0] w;
    c = seed;
    for (int k = 0; k < n; k++) begin
      w = cur_words[k];
      for (int i = 31; i >= 0; i--) c = step(c, w[i], poly);
    end
    golden = c;
  endfunction

  // Engine model: seed load keeps it idle; a word pass takes 32 shift cycles.
  logic [31:0] eng_crc, eng_sh;
  int          eng_cnt;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      eng_crc <= 32'h0; eng_sh <= 32'h0; eng_cnt <= 0; crc_ready <= 1'b1;
    end else if (crc_reset) begin
      eng_crc <= crc_data_in;
    end else if (crc_start) begin
      eng_sh <= crc_data_in; eng_cnt <= 32; crc_ready <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_crc <= step(eng_crc, eng_sh[31], crc_orient);
      eng_sh  <= eng_sh << 1;
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) crc_ready <= 1'b1;
    end
  end
  assign crc_data_out = eng_crc;

  // Word source
  always @(negedge CLK) begin
    word_valid = (wq.size() != 0);
    word_data  = (wq.size() != 0) ? wq[0] : 32'h0;
  end

  // Event recorder, sampling DUT outputs as seen by the active edge
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (nRST) begin
      if (msg_start && !msg_busy) t_start = cyc;
      if (res_valid && !rv_prev) t_valid = cyc;
      rv_prev = res_valid;
      if (!crc_start && !crc_reset && crc_data_in !== 32'h0) dz_bad++;
      if (msg_busy && crc_orient !== exp_poly) orient_bad++;
      if (word_ready && occ >= DEPTH) full_bad++;
      if (word_ready && acc_log.size() >= cur_len) over_bad++;
      if (crc_reset) begin n_reset++; rst_data = crc_data_in; end
      if (crc_start) begin st_q.push_back(cyc); sd_q.push_back(crc_data_in); occ--; end
      if (word_valid && word_ready) begin
        acc_log.push_back(word_data);
        tmp = wq.pop_front();
        occ++;
      end
    end
  end

  // Result monitor: pops the scoreboard whenever a result is presented
  initial begin
    logic [31:0] e;
    res_ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (res_valid && !res_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=%h required=none", res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e);
        end
        res_ack = 1'b1;
      end else begin
        res_ack = 1'b0;
      end
    end
  end

  task automatic send(input int len, input logic [31:0] seed, input logic [31:0] poly);
    cur_len = len; exp_poly = poly;
    acc_log.delete(); st_q.delete(); sd_q.delete(); n_reset = 0; occ = 0;
    @(negedge CLK);
    msg_start = 1'b1; msg_len = LEN_W'(len); msg_seed = seed; msg_poly = poly;
    @(negedge CLK);
    msg_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || msg_busy) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_complete"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    cur_words.delete(); wq.delete();
    for (int i = 0; i < n; i++) begin
      cur_words.push_back(base ^ (32'h01010101 * i));
      wq.push_back(base ^ (32'h01010101 * i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    nRST = 1'b0; msg_start = 1'b0; msg_len = '0; msg_seed = 32'h0; msg_poly = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst_ctrl", 32'({msg_busy, msg_err, word_ready, res_valid, crc_start, crc_reset}), 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_crc_data_in", crc_data_in, 32'h0);
    chk("rst_orient", crc_orient, 32'h0);
    nRST = 1'b1;
    @(negedge CLK);

    // len=0: result is the seed, one cycle after start, no engine activity
    cur_words.delete(); wq.delete();
    exp_q.push_back(32'hFFFFFFFF);
    send(0, 32'hFFFFFFFF, 32'h04C11DB7);
    chk("t1_valid_next_cycle", 32'(res_valid), 32'd1);
    wait_idle("t1");
    chk("t1_latency", 32'(t_valid - t_start), 32'd1);
    chk("t1_engine_strobes", 32'(st_q.size() + n_reset), 32'd0);
    chk("t1_busy_after_ack", 32'(msg_busy), 32'd0);

    // len=1 single word
    cur_words.delete(); wq.delete();
    cur_words.push_back(32'h12345678); wq.push_back(32'h12345678);
    exp_q.push_back(golden(32'hFFFFFFFF, 32'h04C11DB7, 1));
    send(1, 32'hFFFFFFFF, 32'h04C11DB7);
    wait_idle("t2");
    chk("t2_reset_pulses", 32'(n_reset), 32'd1);
    chk("t2_reset_data", rst_data, 32'hFFFFFFFF);
    chk("t2_start_pulses", 32'(st_q.size()), 32'd1);
    if (sd_q.size() == 1) chk("t2_start_data", sd_q[0], 32'h12345678);
    chk("t2_latency", 32'(t_valid - t_start), 32'd36);

    // len=4 with words available before start: back-to-back passes
    load_words(4, 32'hA5A50F0F);
    exp_q.push_back(golden(32'hFFFFFFFF, 32'h04C11DB7, 4));
    orient_bad = 0; dz_bad = 0;
    send(4, 32'hFFFFFFFF, 32'h04C11DB7);
    wait_idle("t3");
    chk("t3_start_pulses", 32'(st_q.size()), 32'd4);
    for (int i = 1; i < st_q.size(); i++) chk("t3_start_gap", 32'(st_q[i] - st_q[i-1]), 32'd33);
    chk("t3_latency", 32'(t_valid - t_start), 32'd135);
    chk("t3_orient_stable", 32'(orient_bad), 32'd0);
    chk("t3_data_in_idle_zero", 32'(dz_bad), 32'd0);

    // len=8 with 16 words offered: flow control and length limit
    load_words(16, 32'h3C3C1234);
    cur_words = cur_words[0:7];
    exp_q.push_back(golden(32'h0BADF00D, 32'h04C11DB7, 8));
    full_bad = 0; over_bad = 0;
    send(8, 32'h0BADF00D, 32'h04C11DB7);
    wait_idle("t4");
    chk("t4_accepted", 32'(acc_log.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < acc_log.size() && i < 8; i++) if (acc_log[i] !== cur_words[i]) bad++;
    chk("t4_order", 32'(bad), 32'd0);
    chk("t4_ready_when_full", 32'(full_bad), 32'd0);
    chk("t4_ready_after_len", 32'(over_bad), 32'd0);
    chk("t4_left_offered", 32'(wq.size()), 32'd8);
    wq.delete();
    @(negedge CLK);

    // msg_start during WAIT: flagged, message unaffected
    load_words(2, 32'h55AA7711);
    exp_q.push_back(golden(32'h00000000, 32'h04C11DB7, 2));
    orient_bad = 0;
    send(2, 32'h00000000, 32'h04C11DB7);
    bad = 0;
    while (st_q.size() < 1 && bad < 100) begin @(negedge CLK); bad++; end
    repeat (5) @(negedge CLK);
    msg_start = 1'b1; msg_len = 8'd3; msg_seed = 32'hDEADBEEF; msg_poly = 32'h1EDC6F41;
    @(negedge CLK);
    msg_start = 1'b0;
    chk("t5_err_set", 32'(msg_err), 32'd1);
    wait_idle("t5");
    chk("t5_err_sticky", 32'(msg_err), 32'd1);
    chk("t5_orient_unaffected", 32'(orient_bad), 32'd0);

    // Reset mid-word aborts, then a fresh message completes correctly
    load_words(1, 32'h0F1E2D3C);
    exp_q.push_back(golden(32'hFFFFFFFF, 32'h04C11DB7, 1));
    send(1, 32'hFFFFFFFF, 32'h04C11DB7);
    chk("t6_err_cleared", 32'(msg_err), 32'd0);
    repeat (12) @(negedge CLK);
    nRST = 1'b0;
    exp_q.delete(); wq.delete(); occ = 0;
    #1;
    chk("t6_rst_ctrl", 32'({msg_busy, msg_err, word_ready, res_valid, crc_start, crc_reset}), 32'h0);
    chk("t6_rst_data", res_data | crc_data_in | crc_orient, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    cur_words.delete(); wq.delete();
    cur_words.push_back(32'hCAFEF00D); wq.push_back(32'hCAFEF00D);
    exp_q.push_back(golden(32'h12345678, 32'h04C11DB7, 1));
    send(1, 32'h12345678, 32'h04C11DB7);
    wait_idle("t6");
    chk("t6_start_pulses", 32'(st_q.size()), 32'd1);
    if (sd_q.size() == 1) chk("t6_start_data", sd_q[0], 32'hCAFEF00D);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
